// File: rtl/ram_master_pkg.sv
// Shared opcodes and FSM state encoding for the RAM initiator.
package ram_master_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_CHECK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FILL,
        S_CHECK,
        S_DRAIN,
        S_RESP
    } state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Delay line matching the RAM read latency; carries a valid flag and the
// word we expect to see when the read data comes back.
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/ram_master.sv
// Command-driven initiator for a single-port synchronous RAM: single
// write/read plus pattern fill and pattern check over an address range.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_cnt;
    logic [2:0]        r_drainCnt;
    logic [DATA_W-1:0] r_rdWord;
    logic [ADDR_W:0]   r_mismatch;
    logic              w_issue;
    logic              w_pipeValid;
    logic [DATA_W-1:0] w_pipeData;

    assign w_issue = (r_state == S_READ) || (r_state == S_CHECK);

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_LAT)
    ) u_rdPipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_data  (r_data),
        .o_valid (w_pipeValid),
        .o_data  (w_pipeData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: w_nextState = S_WRITE;
                        OP_READ:  w_nextState = S_READ;
                        OP_FILL:  w_nextState = S_FILL;
                        default:  w_nextState = S_CHECK;
                    endcase
                end
            end
            S_WRITE: w_nextState = S_RESP;
            S_READ:  w_nextState = S_DRAIN;
            S_FILL:  if (r_cnt == '0) w_nextState = S_RESP;
            S_CHECK: if (r_cnt == '0) w_nextState = S_DRAIN;
            S_DRAIN: if (r_drainCnt == 3'd0) w_nextState = S_RESP;
            S_RESP:  if (rsp_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        ram_we    = (r_state == S_WRITE) || (r_state == S_FILL);
        rsp_valid = (r_state == S_RESP);
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (r_state == S_RESP) begin
            if (r_op == OP_READ) begin
                rsp_data = r_rdWord;
            end else if (r_op == OP_CHECK) begin
                rsp_data = DATA_W'(r_mismatch);
                rsp_err  = (r_mismatch != '0);
            end
        end
    end

    // Address/pattern advance on every burst beat except the last, so the
    // RAM port keeps showing the final word once the command is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_WRITE;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_drainCnt <= '0;
            r_rdWord   <= '0;
            r_mismatch <= '0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_op       <= cmd_op;
                r_addr     <= cmd_addr;
                r_data     <= cmd_data;
                r_cnt      <= cmd_len;
                r_mismatch <= '0;
            end
            if ((r_state == S_FILL || r_state == S_CHECK) && r_cnt != '0) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_data <= r_data + DATA_W'(1);
                r_cnt  <= r_cnt - ADDR_W'(1);
            end
            if (r_state == S_READ || (r_state == S_CHECK && r_cnt == '0)) begin
                r_drainCnt <= 3'(RD_LAT - 1);
            end else if (r_state == S_DRAIN && r_drainCnt != 3'd0) begin
                r_drainCnt <= r_drainCnt - 3'd1;
            end
            if (w_pipeValid) begin
                if (r_op == OP_READ) begin
                    r_rdWord <= ram_rdata;
                end else if (ram_rdata != w_pipeData) begin
                    r_mismatch <= r_mismatch + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_data;

endmodule
